// File: rtl/piece_dropper.sv
// rtl/piece_dropper.sv - drop-piece move sequencer for a gravity board game
//
// Accepts a column/player move request, scans the column bottom-up through an
// external board read port, writes the piece into the lowest empty cell, starts
// an external victory checker and reports the outcome. End-of-game flags are
// sticky until reset.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   drop_valid/drop_ready        move handshake; drop_col, player = move request
//   read_row/read_col, data_in   board read address and combinational cell value
//   write_en/row/col/data        one-cycle board write
//   move_row/move_col            coordinates of the last placed piece
//   start_check, done_checking   victory checker start pulse / completion
//   winner                       victory checker result (00 = none)
//   move_done, move_invalid      one-cycle outcome pulses
//   game_over, draw, game_winner sticky end-of-game state

module piece_dropper #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  input  logic [1:0] player,
  output logic       drop_ready,
  output logic [2:0] read_row,
  output logic [2:0] read_col,
  input  logic [1:0] data_in,
  output logic       write_en,
  output logic [2:0] write_row,
  output logic [2:0] write_col,
  output logic [1:0] write_data,
  output logic [2:0] move_row,
  output logic [2:0] move_col,
  output logic       start_check,
  input  logic       done_checking,
  input  logic [1:0] winner,
  output logic       move_done,
  output logic       move_invalid,
  output logic       game_over,
  output logic       draw,
  output logic [1:0] game_winner
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [3:0] COLS_W   = 4'(COLS);
  localparam logic [6:0] CELLS    = 7'(ROWS * COLS);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WRITE, S_START, S_WAIT, S_REPORT, S_REJECT
  } state_t;

  state_t     state, state_next;
  logic [2:0] col_q;
  logic [1:0] player_q;
  logic [2:0] scan_row;
  logic [6:0] move_count;
  logic [1:0] winner_q;
  logic       accept;
  logic       bad_req;
  logic       cell_empty;

  assign accept     = drop_valid && drop_ready;
  assign bad_req    = (player == 2'b00) || (player == 2'b11) || ({1'b0, drop_col} >= COLS_W);
  assign cell_empty = (data_in == 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = bad_req ? S_REJECT : S_SCAN;
      S_SCAN: begin
        if (cell_empty)                state_next = S_WRITE;
        else if (scan_row == LAST_ROW) state_next = S_REJECT;
      end
      S_WRITE:  state_next = S_START;
      S_START:  state_next = S_WAIT;
      S_WAIT:   if (done_checking) state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      S_REJECT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Move datapath and sticky game state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      player_q    <= '0;
      scan_row    <= '0;
      move_count  <= '0;
      winner_q    <= '0;
      move_row    <= '0;
      move_col    <= '0;
      game_over   <= 1'b0;
      draw        <= 1'b0;
      game_winner <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            col_q    <= drop_col;
            player_q <= player;
            scan_row <= '0;
          end
        end
        S_SCAN: begin
          // move_row doubles as the write target; it is only updated when a
          // target is found, so a full column leaves it untouched.
          if (cell_empty) begin
            move_row <= scan_row;
            move_col <= col_q;
          end else if (scan_row != LAST_ROW) begin
            scan_row <= scan_row + 3'd1;
          end
        end
        S_WRITE: move_count <= move_count + 7'd1;
        S_WAIT:  if (done_checking) winner_q <= winner;
        S_REPORT: begin
          if (winner_q != 2'b00) begin
            game_over   <= 1'b1;
            game_winner <= winner_q;
          end else if (move_count == CELLS) begin
            game_over <= 1'b1;
            draw      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; drop_ready is gated by rst_n so every output
  // reads 0 while reset is held.
  always_comb begin
    drop_ready   = 1'b0;
    read_row     = '0;
    read_col     = '0;
    write_en     = 1'b0;
    write_row    = '0;
    write_col    = '0;
    write_data   = '0;
    start_check  = 1'b0;
    move_done    = 1'b0;
    move_invalid = 1'b0;
    case (state)
      S_IDLE: drop_ready = rst_n && !game_over;
      S_SCAN: begin
        read_row = scan_row;
        read_col = col_q;
      end
      S_WRITE: begin
        write_en   = 1'b1;
        write_row  = move_row;
        write_col  = col_q;
        write_data = player_q;
      end
      S_START:  start_check  = 1'b1;
      S_REPORT: move_done    = 1'b1;
      S_REJECT: move_invalid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piece_dropper.sv
// tb/tb_piece_dropper.sv - scoreboard testbench for piece_dropper

module tb_piece_dropper;

  localparam int ROWS = 4;
  localparam int COLS = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drop_valid = 1'b0;
  logic [2:0] drop_col = '0;
  logic [1:0] player = '0;
  logic       drop_ready;
  logic [2:0] read_row, read_col;
  logic [1:0] data_in;
  logic       write_en;
  logic [2:0] write_row, write_col;
  logic [1:0] write_data;
  logic [2:0] move_row, move_col;
  logic       start_check;
  logic       done_checking = 1'b0;
  logic [1:0] winner = '0;
  logic       move_done, move_invalid, game_over, draw;
  logic [1:0] game_winner;

  piece_dropper #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .drop_valid(drop_valid), .drop_col(drop_col),
    .player(player), .drop_ready(drop_ready), .read_row(read_row),
    .read_col(read_col), .data_in(data_in), .write_en(write_en),
    .write_row(write_row), .write_col(write_col), .write_data(write_data),
    .move_row(move_row), .move_col(move_col), .start_check(start_check),
    .done_checking(done_checking), .winner(winner), .move_done(move_done),
    .move_invalid(move_invalid), .game_over(game_over), .draw(draw),
    .game_winner(game_winner)
  );

  always #5 clk = ~clk;

  // External board memory
  logic [1:0] board [0:7][0:7];
  logic       clear_req = 1'b0;
  assign data_in = board[read_row][read_col];

  always @(posedge clk) begin
    if (clear_req) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r][c] <= 2'b00;
    end else if (write_en) begin
      board[write_row][write_col] <= write_data;
    end
  end

  typedef struct {
    bit inv;
    int row;
    int col;
    int data;
    int acc;
    int inv_edge;
  } sb_t;

  sb_t sb_q[$];
  int  height [0:7];
  int  edge_n = 0;
  int  wr_n = -100;
  int  done_n = -100;
  int  checks = 0;
  int  errors = 0;
  sb_t mon_e;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on outcome pulses
  always @(negedge clk) begin
    if (rst_n) begin
      expect_eq("pulse_excl", 32'(int'(write_en) + int'(start_check) + int'(move_done) + int'(move_invalid) <= 1), 1);
      if (!write_en) expect_eq("wr_idle_zero", {write_row, write_col, write_data}, 0);
      if (done_checking) done_n = edge_n;
      if (write_en) begin
        wr_n = edge_n;
        if (sb_q.size() == 0) expect_eq("wr_unexpected", 1, 0);
        else begin
          mon_e = sb_q[0];
          expect_eq("wr_kind", mon_e.inv, 0);
          expect_eq("wr_row", write_row, mon_e.row);
          expect_eq("wr_col", write_col, mon_e.col);
          expect_eq("wr_data", write_data, mon_e.data);
          expect_eq("wr_lat", edge_n, mon_e.acc + mon_e.row + 2);
        end
      end
      if (start_check) expect_eq("sc_lat", edge_n, wr_n + 1);
      if (move_done) begin
        if (sb_q.size() == 0) expect_eq("md_unexpected", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          expect_eq("md_kind", mon_e.inv, 0);
          expect_eq("md_lat", edge_n, done_n + 1);
        end
      end
      if (move_invalid) begin
        if (sb_q.size() == 0) expect_eq("mi_unexpected", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          expect_eq("mi_kind", mon_e.inv, 1);
          expect_eq("mi_lat", edge_n, mon_e.inv_edge);
        end
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_move(input int c, input logic [1:0] p, input logic [1:0] w, input bit abort);
    sb_t e;
    expect_eq("ready", drop_ready, 1);
    drop_valid = 1'b1;
    drop_col   = 3'(c);
    player     = p;
    @(posedge clk);
    e.acc  = edge_n;
    e.col  = c;
    e.data = p;
    e.row  = 0;
    e.inv_edge = 0;
    if (p == 2'b00 || p == 2'b11 || c >= COLS) begin
      e.inv = 1;
      e.inv_edge = edge_n + 1;
    end else if (height[c] >= ROWS) begin
      e.inv = 1;
      e.inv_edge = edge_n + ROWS + 1;
    end else begin
      e.inv = 0;
      e.row = height[c];
      height[c]++;
    end
    sb_q.push_back(e);
    #1;
    drop_valid = 1'b0;
    drop_col   = '0;
    player     = '0;
    if (!e.inv) begin
      for (int i = 0; i < 20 && start_check !== 1'b1; i++) @(negedge clk);
      if (start_check !== 1'b1) expect_eq("sc_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (abort) return;
      repeat (2) @(posedge clk);
      #1;
      done_checking = 1'b1;
      winner = w;
      @(posedge clk);
      #1;
      done_checking = 1'b0;
      winner = '0;
    end
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    expect_eq("sb_drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit clear);
    rst_n = 1'b0;
    #1;
    expect_eq("rst_outs", {drop_ready, read_row, read_col, write_en, write_row, write_col,
                           write_data, move_row, move_col, start_check, move_done,
                           move_invalid, game_over, draw, game_winner}, 0);
    sb_q.delete();
    if (clear) begin
      clear_req = 1'b1;
      for (int i = 0; i < 8; i++) height[i] = 0;
    end
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("rst_ready", drop_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) height[i] = 0;
    @(posedge clk);
    #1;
    do_reset(1);

    // Empty column 3
    do_move(3, 2'b01, 2'b00, 0);
    expect_eq("c3_over", game_over, 0);
    expect_eq("c3_pos", {move_row, move_col}, {3'd0, 3'd3});

    // Stack column 5 to the top row
    do_move(5, 2'b10, 2'b00, 0);
    do_move(5, 2'b01, 2'b00, 0);
    do_move(5, 2'b10, 2'b00, 0);
    do_move(5, 2'b01, 2'b00, 0);
    expect_eq("c5_pos", {move_row, move_col}, {3'd3, 3'd5});

    // Full column, then malformed requests
    do_move(5, 2'b10, 2'b00, 0);
    expect_eq("full_pos", {move_row, move_col}, {3'd3, 3'd5});
    do_move(0, 2'b11, 2'b00, 0);
    do_move(7, 2'b01, 2'b00, 0);
    do_move(1, 2'b00, 2'b00, 0);
    expect_eq("inv_pos", {move_row, move_col}, {3'd3, 3'd5});

    // Stray done_checking while idle
    done_checking = 1'b1;
    winner = 2'b10;
    @(posedge clk);
    #1;
    done_checking = 1'b0;
    winner = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("stray_over", game_over, 0);

    // Reset while waiting for the checker, then a normal move
    do_move(0, 2'b01, 2'b00, 1);
    do_reset(0);
    do_move(0, 2'b10, 2'b00, 0);
    expect_eq("post_rst_pos", {move_row, move_col}, {3'd1, 3'd0});

    // Win ends the game; further requests are ignored
    do_move(2, 2'b10, 2'b10, 0);
    expect_eq("win_over", game_over, 1);
    expect_eq("win_who", game_winner, 2'b10);
    expect_eq("win_draw", draw, 0);
    drop_valid = 1'b1;
    drop_col   = 3'd1;
    player     = 2'b01;
    for (int i = 0; i < 6; i++) begin
      expect_eq("ign_ready", drop_ready, 0);
      @(posedge clk);
      #1;
      expect_eq("ign_read", {read_row, read_col}, 0);
    end
    drop_valid = 1'b0;
    player     = '0;
    drop_col   = '0;

    // Fill the board with no winner
    do_reset(1);
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        do_move(c, (r % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 0);
        if (c * ROWS + r == ROWS * COLS - 2) expect_eq("pre_draw_over", game_over, 0);
      end
    end
    expect_eq("draw_over", game_over, 1);
    expect_eq("draw_flag", draw, 1);
    expect_eq("draw_who", game_winner, 0);
    expect_eq("draw_ready", drop_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
